inv_rot_word_seq: RTL and testbench
===================================

Name: inv_rot_word_seq

Overview:
- Multi-cycle inverse of the row-major byte-rotate stage used in key-schedule and state handling.
- Accepts a 128-bit row-major word, rotates each row RIGHT by a mode-dependent byte count, and repacks the result to column-major.
- Rotation is one byte-step per cycle.
- Sits on the decrypt path between key/state storage and the inverse round datapath, with valid/ready handshakes on both sides.

Parameters:
- ROT_MODE, 0, 0 = uniform right-rotate by 1 byte on all rows; 1 = InvShiftRows (row r right-rotated by r bytes).
- STEPS, derived (ROT_MODE ? 3 : 1), number of ROT cycles; localparam, not overridable.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  128  row-major word {row0,row1,row2,row3}; each row is {c0,c1,c2,c3} with c0 in the MSB.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept.
- out_data  output  128  column-major result {col0..col3}; each col is {r0,r1,r2,r3} with r0 in the MSB.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- busy  output  1  high in ROT or DONE.

Behaviour:
- FSM states: IDLE, ROT, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0, work reg=0, step counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the 4x32 work register, clear the step counter, go to ROT.
- ROT:
  - in_ready=0.
  - Each cycle, every row r whose required count exceeds the current step is rotated right by one byte: {a0,a1,a2,a3} -> {a3,a0,a1,a2}.
  - Required count: ROT_MODE=0 -> 1 for all rows. ROT_MODE=1 -> r (row0 never rotates).
  - Step counter increments each cycle. At step==STEPS-1, go to DONE.
- DONE:
  - out_valid=1. out_data is the work register repacked column-major, driven from a register (not combinational from the work register).
  - out_data holds stable while out_valid && !out_ready.
  - On out_ready: out_valid drops and the FSM returns to IDLE.
- Latency: out_valid rises STEPS cycles after the accepting edge (1 cycle for mode 0, 3 cycles for mode 1). Minimum handshake-to-handshake spacing is STEPS+2 cycles.
- No overlap: in_ready=0 in ROT and DONE. in_valid during those states is ignored and must be held by the source.
- in_valid with no handshake must not disturb the work register.
- Simultaneous out_ready in DONE with in_valid: only the output handshake completes that cycle; the new input is accepted the following cycle in IDLE.
- rst asserted mid-operation: immediate return to reset values; any in-flight word is discarded with no partial output.
- Width rules: pure byte permutation, no arithmetic. The step counter is 2 bits and never wraps during ROT.

Optional Feature:
- Macro: INV_ROT_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit), a synchronous abort.
  - flush=1 in ROT or DONE: next edge goes to IDLE, out_valid=0, work register and counter cleared.
  - flush in IDLE clears the work register and blocks acceptance that cycle (in_ready=0 while flush=1).
  - flush has priority over both handshakes.
- Undefined: no flush port; behaviour exactly as above.

Test Plan:
- Reset mid-ROT (ROT_MODE=1): accept a word, assert rst 1 cycle later -> out_valid=0, in_ready=1, out_data=0 immediately; next accepted word produces its correct result.
- ROT_MODE=0: in_data=0x00010203_10111213_20212223_30313233, out_ready=1 -> out_data=0x03132333_00102030_01112131_02122232, out_valid high exactly 1 cycle after acceptance, for one cycle.
- ROT_MODE=1: same input -> out_data=0x00132231_01102332_02112033_03122130, out_valid 3 cycles after acceptance; busy high from acceptance until the output handshake.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_data/out_valid stable; in_ready=0; a second in_valid is not accepted until the cycle after out_ready=1.
- Round-trip: random 128-bit column-major K, convert with the forward row-major left-rotate-by-1 stage, feed to ROT_MODE=0 -> out_data==K over 1000 vectors.
- INV_ROT_FLUSH_EN: flush during ROT (mode 1, step 1) -> no out_valid pulse, IDLE next cycle; flush in IDLE with in_valid=1 -> no acceptance that cycle.

Source files
------------

// File: rtl/inv_rot_word_seq.sv
// Multi-cycle inverse row rotate: rotates each row right one byte per cycle, then repacks column-major.
// Optional synchronous abort input 'flush' is present only when INV_ROT_FLUSH_EN is defined.
module inv_rot_word_seq #(
  parameter int ROT_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
`ifdef INV_ROT_FLUSH_EN
  input  logic         flush,
`endif
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int         STEPS     = (ROT_MODE != 0) ? 3 : 1;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROT  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_r, state_nx_s;
  logic [1:0]        step_r, step_nx_s;
  logic [3:0][31:0]  work_r, work_nx_s;
  logic [127:0]      out_data_r, out_data_nx_s;
  logic              in_ready_r, out_valid_r, busy_r;
  logic              flush_s, accept_s;

  function automatic logic [31:0] rot_right_byte(input logic [31:0] row);
    rot_right_byte = {row[7:0], row[31:8]};
  endfunction

  // Number of right-rotate steps row r needs in total.
  function automatic logic [1:0] row_req(input int r);
    if (ROT_MODE != 0) begin
      row_req = 2'(r);
    end else begin
      row_req = 2'd1;
    end
  endfunction

  function automatic logic [127:0] to_col_major(input logic [3:0][31:0] rows);
    logic [127:0] w;
    w = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w[127 - 32*c - 8*r -: 8] = rows[r][31 - 8*c -: 8];
      end
    end
    return w;
  endfunction

`ifdef INV_ROT_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign in_ready  = in_ready_r & ~flush_s;
  assign accept_s  = in_valid & in_ready;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

  // Next-state, work-register and output-data computation.
  always_comb begin
    state_nx_s    = state_r;
    step_nx_s     = step_r;
    work_nx_s     = work_r;
    out_data_nx_s = out_data_r;
    if (flush_s) begin
      state_nx_s = ST_IDLE;
      step_nx_s  = 2'd0;
      work_nx_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int r = 0; r < 4; r++) begin
              work_nx_s[r] = in_data[127 - 32*r -: 32];
            end
            step_nx_s  = 2'd0;
            state_nx_s = ST_ROT;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_ROT: begin
          for (int r = 0; r < 4; r++) begin
            if (row_req(r) > step_r) begin
              work_nx_s[r] = rot_right_byte(work_r[r]);
            end else begin
              work_nx_s[r] = work_r[r];
            end
          end
          step_nx_s = step_r + 2'd1;
          if (step_r == LAST_STEP) begin
            state_nx_s    = ST_DONE;
            out_data_nx_s = to_col_major(work_nx_s);
          end else begin
            state_nx_s = ST_ROT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          step_nx_s  = 2'd0;
          work_nx_s  = '0;
        end
      endcase
    end
  end

  // State and registered outputs; handshake flags derive from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      step_r      <= 2'd0;
      work_r      <= '0;
      out_data_r  <= 128'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      step_r      <= step_nx_s;
      work_r      <= work_nx_s;
      out_data_r  <= out_data_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_inv_rot_word_seq.sv
// Directed bench for inv_rot_word_seq: one instance per ROT_MODE, hand-computed vectors,
// plus a round trip through a forward left-rotate model. Flush cases run under INV_ROT_FLUSH_EN.
module tb_inv_rot_word_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] in_data0, in_data1, out_data0, out_data1;
  logic         in_valid0, in_valid1, in_ready0, in_ready1;
  logic         out_valid0, out_valid1, out_ready0, out_ready1;
  logic         busy0, busy1;
`ifdef INV_ROT_FLUSH_EN
  logic         flush0, flush1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] VEC_A  = 128'h00010203_10111213_20212223_30313233;
  localparam logic [127:0] EXP_A0 = 128'h03132333_00102030_01112131_02122232;
  localparam logic [127:0] EXP_A1 = 128'h00132231_01102332_02112033_03122130;
  localparam logic [127:0] VEC_B  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] EXP_B0 = 128'h3377bbff_004488cc_115599dd_2266aaee;
  localparam logic [127:0] EXP_B1 = 128'h0077aadd_1144bbee_225588ff_336699cc;

  inv_rot_word_seq #(.ROT_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst),
`ifdef INV_ROT_FLUSH_EN
    .flush(flush0),
`endif
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .busy(busy0)
  );

  inv_rot_word_seq #(.ROT_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef INV_ROT_FLUSH_EN
    .flush(flush1),
`endif
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .busy(busy1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forward stage: column-major K -> row-major, each row rotated left by one byte.
  function automatic logic [127:0] fwd_rot(input logic [127:0] k);
    logic [127:0] w;
    w = 128'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w[127 - 32*r - 8*c -: 8] = k[127 - 32*((c + 1) % 4) - 8*r -: 8];
      end
    end
    return w;
  endfunction

  task automatic run0(input logic [127:0] d, input logic [127:0] e, input string tag);
    chk({tag, "_ir0"}, in_ready0, 1'b1);
    in_data0 = d; in_valid0 = 1'b1; out_ready0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    chk({tag, "_busy"}, busy0, 1'b1);
    chk({tag, "_ir"}, in_ready0, 1'b0);
    chk({tag, "_v0"}, out_valid0, 1'b0);
    tick();
    chk({tag, "_v1"}, out_valid0, 1'b1);
    chk({tag, "_data"}, out_data0, e);
    tick();
    chk({tag, "_v2"}, out_valid0, 1'b0);
    chk({tag, "_ir2"}, in_ready0, 1'b1);
  endtask

  task automatic run1(input logic [127:0] d, input logic [127:0] e, input string tag);
    chk({tag, "_ir0"}, in_ready1, 1'b1);
    in_data1 = d; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk({tag, "_v0"}, out_valid1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      chk({tag, "_busy"}, busy1, 1'b1);
      tick();
      chk({tag, "_v"}, out_valid1, (i == 3) ? 1'b1 : 1'b0);
    end
    chk({tag, "_data"}, out_data1, e);
    chk({tag, "_busyd"}, busy1, 1'b1);
    tick();
    chk({tag, "_vend"}, out_valid1, 1'b0);
    chk({tag, "_bend"}, busy1, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] k;
    int wait_n;
    rst = 1'b1;
    in_data0 = 128'd0; in_data1 = 128'd0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    out_ready0 = 1'b0; out_ready1 = 1'b0;
`ifdef INV_ROT_FLUSH_EN
    flush0 = 1'b0; flush1 = 1'b0;
`endif
    tick(); tick();
    chk("rst_ir", in_ready1, 1'b1);
    chk("rst_v", out_valid1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_data", out_data1, 128'd0);
    chk("rst_data0", out_data0, 128'd0);
    rst = 1'b0;
    tick();

    run0(VEC_A, EXP_A0, "m0a");
    run0(VEC_B, EXP_B0, "m0b");
    run1(VEC_A, EXP_A1, "m1a");

    // Reset one cycle after acceptance, in the middle of rotation.
    in_data1 = VEC_A; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_v", out_valid1, 1'b0);
    chk("mid_rst_ir", in_ready1, 1'b1);
    chk("mid_rst_data", out_data1, 128'd0);
    chk("mid_rst_busy", busy1, 1'b0);
    tick();
    rst = 1'b0;
    run1(VEC_B, EXP_B1, "rcv");

    // Backpressure: hold DONE for 5 cycles while a second word waits.
    in_data1 = VEC_B; in_valid1 = 1'b1; out_ready1 = 1'b0;
    tick();
    in_data1 = VEC_A;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_v", out_valid1, 1'b1);
      chk("bp_data", out_data1, EXP_B1);
      chk("bp_ir", in_ready1, 1'b0);
      tick();
    end
    out_ready1 = 1'b1;
    tick();
    chk("bp_hs_v", out_valid1, 1'b0);
    chk("bp_hs_busy", busy1, 1'b0);
    chk("bp_hs_ir", in_ready1, 1'b1);
    tick();
    in_valid1 = 1'b0;
    chk("bp_acc_busy", busy1, 1'b1);
    tick(); tick(); tick();
    chk("bp2_v", out_valid1, 1'b1);
    chk("bp2_data", out_data1, EXP_A1);
    tick();
    chk("bp2_vend", out_valid1, 1'b0);

`ifdef INV_ROT_FLUSH_EN
    // Flush in ROT at step 1 aborts without an output pulse.
    in_data1 = VEC_A; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    chk("fl_v", out_valid1, 1'b0);
    chk("fl_busy", busy1, 1'b0);
    chk("fl_ir", in_ready1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_nov", out_valid1, 1'b0);
    end
    // Flush in IDLE blocks acceptance that cycle.
    flush1 = 1'b1; in_valid1 = 1'b1; in_data1 = VEC_B;
    #1;
    chk("fli_ir", in_ready1, 1'b0);
    tick();
    chk("fli_busy", busy1, 1'b0);
    flush1 = 1'b0;
    tick();
    in_valid1 = 1'b0;
    chk("fli_acc", busy1, 1'b1);
    tick(); tick(); tick();
    chk("fli_v", out_valid1, 1'b1);
    chk("fli_data", out_data1, EXP_B1);
    tick();
`endif

    // Round trip through the forward stage on the uniform-rotate instance.
    out_ready0 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      in_data0 = fwd_rot(k); in_valid0 = 1'b1;
      tick();
      in_valid0 = 1'b0;
      wait_n = 0;
      while (!out_valid0 && wait_n < 8) begin
        tick();
        wait_n++;
      end
      chk("rt_valid", out_valid0, 1'b1);
      chk("rt_data", out_data0, k);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
